// File: rtl/poly_coeff_mac_if.sv
// Stream/control bundle for poly_coeff_mac: row/coeff input side, result drain side,
// and status. The master modport is the producer/consumer environment; slave is the MAC.
interface poly_coeff_mac_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned Q_W = 8
);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic            busy;
  logic            row_start;
  logic [Q_W-1:0]  b_in;
  logic            coeff_valid;
  logic [1:0]      coeff_in;
  logic            res_valid;
  logic            res_ready;
  logic [Q_W-1:0]  res_data;
  logic [IdxW-1:0] res_idx;
  logic            done;
  logic            err;

  modport master (
    output start, row_start, b_in, coeff_valid, coeff_in, res_ready,
    input  busy, res_valid, res_data, res_idx, done, err
  );

  modport slave (
    input  start, row_start, b_in, coeff_valid, coeff_in, res_ready,
    output busy, res_valid, res_data, res_idx, done, err
  );
endinterface

// File: rtl/poly_coeff_mac.sv
// Negacyclic polynomial MAC: accumulates coeff(a) * b_j mod Q into N accumulators over
// N rows of N small signed coefficients, then drains c[0..N-1] over valid/ready.
module poly_coeff_mac #(
  parameter int unsigned N   = 4,
  parameter int unsigned Q_W = 8,
  parameter int unsigned Q   = 251
) (
  input logic             clk,
  input logic             rst_n,
  poly_coeff_mac_if.slave bus
);

  localparam int unsigned     IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [Q_W:0]    QExt    = (Q_W + 1)'(Q);
  localparam logic [Q_W-1:0]  QLo     = Q_W'(Q);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

  state_e          state_q, state_d;
  logic [Q_W-1:0]  acc_q [N];
  logic [Q_W-1:0]  acc_d [N];
  logic [IdxW-1:0] col_q, col_d;
  logic [IdxW-1:0] row_q, row_d;
  logic [IdxW-1:0] out_idx_q, out_idx_d;
  logic [Q_W-1:0]  b_q, b_d;
  logic [Q_W-1:0]  b2_q, b2_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [Q_W:0]    b_in_x2;
  logic [Q_W-1:0]  b_in_dbl;
  logic            latch_b;
  logic [Q_W-1:0]  b_eff, b2_eff, acc_cur, sub_op, acc_new;
  logic [Q_W:0]    sum;
  logic            sum_ge_q, sub_neg;

  // Datapath: 2*b_in mod Q, operand selection and single-correction modular add/sub.
  // The final results fit in Q_W bits, so the corrections are done with wrapping Q_W-bit math.
  always_comb begin
    b_in_x2  = {bus.b_in, 1'b0};
    b_in_dbl = {bus.b_in[Q_W-2:0], 1'b0} - ((b_in_x2 >= QExt) ? QLo : '0);

    // A coeff in the same cycle as a legal row_start uses the freshly presented b_in.
    latch_b = (state_q == StAcc) && bus.row_start && (col_q == '0);
    b_eff   = latch_b ? bus.b_in : b_q;
    b2_eff  = latch_b ? b_in_dbl : b2_q;

    acc_cur  = acc_q[col_q];
    sum      = {1'b0, acc_cur} + {1'b0, b_eff};
    sum_ge_q = (sum >= QExt);
    sub_op   = (bus.coeff_in == 2'b10) ? b2_eff : b_eff;
    sub_neg  = (acc_cur < sub_op);

    unique case (bus.coeff_in)
      2'b01:          acc_new = acc_cur + b_eff - (sum_ge_q ? QLo : '0);
      2'b11, 2'b10:   acc_new = acc_cur - sub_op + (sub_neg ? QLo : '0);
      default:        acc_new = acc_cur;
    endcase
  end

  // Next-state logic for the IDLE -> ACC -> DRAIN controller and all datapath registers.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    col_d     = col_q;
    row_d     = row_q;
    out_idx_d = out_idx_q;
    b_d       = b_q;
    b2_d      = b2_q;
    done_d    = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < N; i++) acc_d[i] = '0;
          col_d   = '0;
          row_d   = '0;
          err_d   = 1'b0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (bus.row_start) begin
          if (col_q == '0) begin
            b_d  = bus.b_in;
            b2_d = b_in_dbl;
          end else begin
            // Row coefficient may only change on a row boundary.
            err_d = 1'b1;
          end
        end
        if (bus.coeff_valid) begin
          acc_d[col_q] = acc_new;
          if (col_q == LastIdx) begin
            col_d = '0;
            if (row_q == LastIdx) begin
              row_d     = '0;
              out_idx_d = '0;
              state_d   = StDrain;
            end else begin
              row_d = row_q + IdxW'(1);
            end
          end else begin
            col_d = col_q + IdxW'(1);
          end
        end
      end
      StDrain: begin
        if (bus.res_ready) begin
          if (out_idx_q == LastIdx) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            out_idx_d = out_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      for (int unsigned i = 0; i < N; i++) acc_q[i] <= '0;
      col_q     <= '0;
      row_q     <= '0;
      out_idx_q <= '0;
      b_q       <= '0;
      b2_q      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      col_q     <= col_d;
      row_q     <= row_d;
      out_idx_q <= out_idx_d;
      b_q       <= b_d;
      b2_q      <= b2_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Outputs: results come straight from the accumulator addressed by out_idx.
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.res_valid = (state_q == StDrain);
    bus.res_data  = acc_q[out_idx_q];
    bus.res_idx   = out_idx_q;
    bus.done      = done_q;
    bus.err       = err_q;
  end

endmodule
